// File: rtl/u712_pkg.sv
// Shared definitions for the U712 chip-space cycle sequencer.
package u712_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SLOT = 3'd1,
        ADDR      = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        RECOVER   = 3'd5
    } state_e;

    localparam int unsigned RECOVER_CLKS_DEF = 3;
    localparam int unsigned TIMEOUT_CCK_DEF  = 64;

endpackage

// File: rtl/u712_sync_edge.sv
// Two-flop synchroniser for an asynchronous Agnus signal, with a third
// flop giving single-clock rise/fall pulses of the synchronised level.
module u712_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    always_comb begin
        sh_d = {sh_q[1:0], d};
    end

    // Idles high so a line that is high out of reset produces no edge.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            sh_q <= 3'b111;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign level = sh_q[1];
    assign rise  = sh_q[1] & ~sh_q[2];
    assign fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/u712_chip_cycle.sv
// Sequences one CPU access to chip RAM / custom registers: waits for a free
// Agnus slot aligned to CCK, runs the bus cycle, then pulses AGNUS_TACK.
module u712_chip_cycle
    import u712_pkg::*;
#(
    parameter int unsigned RECOVER_CLKS = RECOVER_CLKS_DEF,
    parameter int unsigned TIMEOUT_CCK  = TIMEOUT_CCK_DEF
) (
    input  logic CLK40,
    input  logic RESETn,
    input  logic TSn,
    input  logic CHIP_SEL,
    input  logic RnW,
    input  logic CCK,
    input  logic DBRn,
    output logic CHIP_CYC,
    output logic DWR_EN,
    output logic LATCH_RD,
    output logic AGNUS_TACK,
    output logic STARVED
);

    localparam int unsigned SLOT_W = $clog2(TIMEOUT_CCK + 1);
    localparam int unsigned REC_W  = $clog2(RECOVER_CLKS + 1);

    logic cck_rise;
    logic cck_fall;
    logic cck_s;
    logic dbr_s;
    logic dbr_rise;
    logic dbr_fall;

    state_e              state_q,      state_d;
    logic                rnw_q,        rnw_d;
    logic [SLOT_W-1:0]   slot_q,       slot_d;
    logic [REC_W-1:0]    rec_q,        rec_d;
    logic                chip_cyc_q,   chip_cyc_d;
    logic                dwr_en_q,     dwr_en_d;
    logic                latch_rd_q,   latch_rd_d;
    logic                agnus_tack_q, agnus_tack_d;
    logic                starved_q,    starved_d;

    u712_sync_edge u_cck_sync (
        .clk   (CLK40),
        .rst_n (RESETn),
        .d     (CCK),
        .level (cck_s),
        .rise  (cck_rise),
        .fall  (cck_fall)
    );

    u712_sync_edge u_dbr_sync (
        .clk   (CLK40),
        .rst_n (RESETn),
        .d     (DBRn),
        .level (dbr_s),
        .rise  (dbr_rise),
        .fall  (dbr_fall)
    );

    // Only the DBRn level and the CCK edges steer the sequencer.
    logic unused_sync;
    assign unused_sync = &{1'b0, cck_s, dbr_rise, dbr_fall};

    always_comb begin
        state_d    = state_q;
        rnw_d      = rnw_q;
        slot_d     = slot_q;
        rec_d      = rec_q;
        starved_d  = starved_q;
        latch_rd_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!TSn && CHIP_SEL) begin
                    rnw_d   = RnW;
                    slot_d  = '0;
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (cck_rise) begin
                    if (dbr_s) begin
                        state_d = ADDR;
                    end else begin
                        if (slot_q != SLOT_W'(TIMEOUT_CCK)) begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                        // Agnus kept the bus too long: terminate without a bus cycle.
                        if (slot_q == SLOT_W'(TIMEOUT_CCK - 1)) begin
                            starved_d = 1'b1;
                            state_d   = ACK;
                        end
                    end
                end
            end
            ADDR: begin
                if (cck_fall) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cck_rise) begin
                    latch_rd_d = rnw_q;
                    state_d    = ACK;
                end
            end
            ACK: begin
                rec_d   = '0;
                state_d = RECOVER;
            end
            RECOVER: begin
                if (rec_q == REC_W'(RECOVER_CLKS - 1)) begin
                    state_d = IDLE;
                end else begin
                    rec_d = rec_q + REC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        chip_cyc_d   = (state_d == ADDR) || (state_d == DATA);
        dwr_en_d     = chip_cyc_d && !rnw_d;
        agnus_tack_d = (state_q == ACK);
    end

    always_ff @(negedge CLK40) begin
        if (!RESETn) begin
            state_q      <= IDLE;
            rnw_q        <= 1'b1;
            slot_q       <= '0;
            rec_q        <= '0;
            chip_cyc_q   <= 1'b0;
            dwr_en_q     <= 1'b0;
            latch_rd_q   <= 1'b0;
            agnus_tack_q <= 1'b0;
            starved_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnw_q        <= rnw_d;
            slot_q       <= slot_d;
            rec_q        <= rec_d;
            chip_cyc_q   <= chip_cyc_d;
            dwr_en_q     <= dwr_en_d;
            latch_rd_q   <= latch_rd_d;
            agnus_tack_q <= agnus_tack_d;
            starved_q    <= starved_d;
        end
    end

    assign CHIP_CYC   = chip_cyc_q;
    assign DWR_EN     = dwr_en_q;
    assign LATCH_RD   = latch_rd_q;
    assign AGNUS_TACK = agnus_tack_q;
    assign STARVED    = starved_q;

endmodule
